uart_tx: RTL and testbench

Serial transmitter that converts a parallel byte, offered on a valid/ready handshake, into an asynchronous UART frame on `tx`. The frame is start bit, data bits LSB-first, an optional parity bit, then stop bits. It sits directly upstream of the UART line: its `tx` output is the serial transmit line that the UART monitor and the far-end receiver observe. All frame timing is derived from `clk` by an integer clocks-per-bit divider.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx.sv | 110 +++++++++++
 tb/tb_uart_tx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and the
// parity rule so transmitter and receiver agree on one definition.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_tx_state_e;

   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;

   // Data is zero-extended to 9 bits, which covers every legal frame width.
   function automatic logic uart_parity(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Clocks-per-bit counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done on
// the last count of every bit period; restart realigns to a bit boundary.
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic bit_done
);

   localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart || bit_done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a valid/ready handshake and shifts it
// out as start, LSB-first data, optional parity and stop bits on tx.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [DATA_BITS-1:0] tx_byte,
   output logic                 tx,
   output logic                 busy
);

   localparam int unsigned   BW        = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   uart_tx_state_e       state;
   uart_tx_state_e       state_next;
   logic                 bit_done;
   logic                 handshake;
   logic                 last_data;
   logic                 last_stop;
   logic                 tx_next;
   logic                 par_bit;
   logic [DATA_BITS-1:0] shreg;
   logic [BW-1:0]        bit_cnt;

   assign handshake = tx_valid && tx_ready;
   assign last_data = bit_done && (bit_cnt == LAST_DATA);
   assign last_stop = bit_done && (bit_cnt == LAST_STOP);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .restart  (handshake),
      .bit_done (bit_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (tx_valid) state_next = ST_START;
         ST_START:  if (bit_done) state_next = ST_DATA;
         ST_DATA:   if (last_data) state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (bit_done) state_next = ST_STOP;
         ST_STOP:   if (last_stop) state_next = tx_valid ? ST_START : ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_ready = 1'b0;
      tx_next  = UART_IDLE_LVL;
      case (state)
         ST_IDLE:   tx_ready = 1'b1;
         ST_START:  tx_next  = UART_START_LVL;
         ST_DATA:   tx_next  = shreg[0];
         ST_PARITY: tx_next  = par_bit;
         ST_STOP:   tx_ready = last_stop;
         default:   tx_next  = UART_IDLE_LVL;
      endcase
   end

   // tx and busy are registered from the state, so the line trails the FSM
   // by one clock; a handshake at edge k shows on tx after edge k+1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx      <= UART_IDLE_LVL;
         busy    <= 1'b0;
         shreg   <= '0;
         par_bit <= 1'b0;
         bit_cnt <= '0;
      end else begin
         tx   <= tx_next;
         busy <= (state != ST_IDLE);

         if (handshake) begin
            shreg   <= tx_byte;
            par_bit <= uart_parity(9'(tx_byte), PARITY_ODD != 0);
         end else if (state == ST_DATA && bit_done) begin
            shreg <= shreg >> 1;
         end

         if (handshake || state_next != state) begin
            bit_cnt <= '0;
         end else if (bit_done && (state == ST_DATA || state == ST_STOP)) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit: base, even/odd parity and
// two-stop-bit configurations, with hand-written frame bit patterns.
module tb_uart_tx;

   logic       clk;
   logic       rst_n;
   logic [3:0] v;
   logic [7:0] d [4];
   logic [3:0] txo;
   logic [3:0] rdy;
   logic [3:0] bsy;

   int total;
   int bad;

   uart_tx #(.CLKS_PER_BIT(4)) u_base (
      .clk(clk), .rst_n(rst_n), .tx_valid(v[0]), .tx_ready(rdy[0]),
      .tx_byte(d[0]), .tx(txo[0]), .busy(bsy[0])
   );

   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
      .clk(clk), .rst_n(rst_n), .tx_valid(v[1]), .tx_ready(rdy[1]),
      .tx_byte(d[1]), .tx(txo[1]), .busy(bsy[1])
   );

   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .tx_valid(v[2]), .tx_ready(rdy[2]),
      .tx_byte(d[2]), .tx(txo[2]), .busy(bsy[2])
   );

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_stop2 (
      .clk(clk), .rst_n(rst_n), .tx_valid(v[3]), .tx_ready(rdy[3]),
      .tx_byte(d[3]), .tx(txo[3]), .busy(bsy[3])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input int s, input string tag);
      chk($sformatf("%s tx s%0d", tag, s), txo[s], 1);
      chk($sformatf("%s busy s%0d", tag, s), bsy[s], 0);
      chk($sformatf("%s ready s%0d", tag, s), rdy[s], 1);
   endtask

   // Offers byte b; one edge later the FSM is in START while tx still idles.
   task automatic start_frame(input int s, input logic [7:0] b, input bit hold,
                              input logic [7:0] nxt);
      v[s] = 1'b1;
      d[s] = b;
      tick();
      if (hold) d[s] = nxt;
      else v[s] = 1'b0;
      chk($sformatf("hs ready s%0d", s), rdy[s], 0);
      chk($sformatf("hs tx s%0d", s), txo[s], 1);
      chk($sformatf("hs busy s%0d", s), bsy[s], 0);
   endtask

   // fbits[i] is the level of bit i on the line; each lasts 4 cycles.
   task automatic check_frames(input int s, input int nframes, input int bpf,
                               input logic [23:0] fbits, input int glitch_at,
                               input int drop_at);
      int f;
      int tot;
      f   = bpf * 4;
      tot = nframes * f;
      for (int j = 0; j < tot; j++) begin
         tick();
         if (glitch_at >= 0 && j == glitch_at) begin
            v[s] = 1'b1;
            d[s] = 8'h00;
         end
         if (glitch_at >= 0 && j == glitch_at + 1) v[s] = 1'b0;
         if (j == drop_at) v[s] = 1'b0;
         chk($sformatf("tx s%0d c%0d", s, j), txo[s], fbits[j/4]);
         chk($sformatf("ready s%0d c%0d", s, j), rdy[s],
             ((j % f) == f - 2) || (j == tot - 1));
         chk($sformatf("busy s%0d c%0d", s, j), bsy[s], 1);
      end
      tick();
      chk_idle(s, "end");
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      v     = '0;
      for (int i = 0; i < 4; i++) d[i] = 8'h00;

      // Reset held for 5 cycles
      for (int c = 0; c < 5; c++) begin
         tick();
         for (int s = 0; s < 4; s++) chk_idle(s, "rst");
      end
      rst_n = 1'b1;
      tick();
      for (int s = 0; s < 4; s++) chk_idle(s, "post_rst");
      tick();

      // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
      start_frame(0, 8'hA5, 1'b0, 8'h00);
      check_frames(0, 1, 10, 24'(10'b1_10100101_0), -1, -1);

      // 0x07 even parity -> parity bit 1
      start_frame(1, 8'h07, 1'b0, 8'h00);
      check_frames(1, 1, 11, 24'(11'b1_1_00000111_0), -1, -1);

      // 0x07 odd parity -> parity bit 0
      start_frame(2, 8'h07, 1'b0, 8'h00);
      check_frames(2, 1, 11, 24'(11'b1_0_00000111_0), -1, -1);

      // Back-to-back 0x55 then 0xAA with tx_valid held: 80 cycles, no gap
      start_frame(0, 8'h55, 1'b1, 8'hAA);
      check_frames(0, 2, 10, 24'({10'b1_10101010_0, 10'b1_01010101_0}), -1, 39);

      // Two stop bits, 0xFF, with a valid pulse and byte change mid-frame
      start_frame(3, 8'hFF, 1'b0, 8'h00);
      check_frames(3, 1, 11, 24'(11'b11_11111111_0), 10, -1);

      // Reset during data bit 3 of 0x00, then a clean 0x3C frame
      start_frame(0, 8'h00, 1'b0, 8'h00);
      for (int j = 0; j < 18; j++) tick();
      chk("pre_abort tx", txo[0], 0);
      chk("pre_abort busy", bsy[0], 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_idle(0, "abort");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk_idle(0, "after_abort");
      start_frame(0, 8'h3C, 1'b0, 8'h00);
      check_frames(0, 1, 10, 24'(10'b1_00111100_0), -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
